// File: rtl/gnrmc_pkg.sv
// Shared constants, state encoding and helpers for the GNRMC sentence transmitter.
package gnrmc_pkg;

    localparam int IDX_W = 5;
    localparam int FRAME_LEN = 23;
    localparam logic [IDX_W-1:0] LAST_IDX   = 5'd22;
    localparam logic [IDX_W-1:0] CSUM_FIRST = 5'd1;
    localparam logic [IDX_W-1:0] CSUM_LAST  = 5'd17;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_DOT    = 8'h2E;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_V      = 8'h56;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_0      = 8'h30;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    function automatic logic [7:0] nibble_to_hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/gnrmc_char_sel.sv
// Byte selector: maps sentence index plus captured time/status/checksum to the ASCII byte.
module gnrmc_char_sel
    import gnrmc_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic [23:0]      bcd,
    input  logic             fix_ok,
    input  logic [7:0]       csum,
    output logic [7:0]       ch
);

    logic       all_ok;
    logic [3:0] dig;
    logic [7:0] dig_ch;

    // A bad nibble prints as '0' and also downgrades the status to void.
    always_comb begin
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (bcd[i*4 +: 4] > 4'd9) all_ok = 1'b0;
    end

    always_comb begin
        dig = 4'd0;
        case (idx)
            5'd7:    dig = bcd[23:20];
            5'd8:    dig = bcd[19:16];
            5'd9:    dig = bcd[15:12];
            5'd10:   dig = bcd[11:8];
            5'd11:   dig = bcd[7:4];
            5'd12:   dig = bcd[3:0];
            default: dig = 4'd0;
        endcase
        dig_ch = (dig > 4'd9) ? ASC_0 : (ASC_0 + {4'h0, dig});
    end

    always_comb begin
        ch = 8'h00;
        case (idx)
            5'd0:                             ch = ASC_DOLLAR;
            5'd1:                             ch = 8'h47; // G
            5'd2:                             ch = 8'h4E; // N
            5'd3:                             ch = 8'h52; // R
            5'd4:                             ch = 8'h4D; // M
            5'd5:                             ch = 8'h43; // C
            5'd6, 5'd16:                      ch = ASC_COMMA;
            5'd7, 5'd8, 5'd9, 5'd10,
            5'd11, 5'd12:                     ch = dig_ch;
            5'd13:                            ch = ASC_DOT;
            5'd14, 5'd15:                     ch = ASC_0;
            5'd17:                            ch = (fix_ok && all_ok) ? ASC_A : ASC_V;
            5'd18:                            ch = ASC_STAR;
            5'd19:                            ch = nibble_to_hex_ascii(csum[7:4]);
            5'd20:                            ch = nibble_to_hex_ascii(csum[3:0]);
            5'd21:                            ch = ASC_CR;
            5'd22:                            ch = ASC_LF;
            default:                          ch = 8'h00;
        endcase
    end

endmodule

// File: rtl/gnrmc_frame_tx.sv
// GNRMC sentence transmitter: walks the 23-byte frame, one byte per UART strobe/done
// handshake, with optional inter-byte gap and a per-byte timeout.
module gnrmc_frame_tx
    import gnrmc_pkg::*;
#(
    parameter int IFG_CYCLES = 0,
    parameter int TX_TIMEOUT = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [23:0] time_bcd,
    input  logic        fix_ok,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        busy,
    output logic        frame_done,
    output logic        tx_err
);

    localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [23:0]      bcd_sh;
    logic             fix_sh;
    logic [7:0]       csum;
    logic [7:0]       hold;
    logic [7:0]       ch;
    logic [TMO_W-1:0] tmo;
    logic [GAP_W-1:0] gap;

    gnrmc_char_sel u_char_sel (
        .idx    (idx),
        .bcd    (bcd_sh),
        .fix_ok (fix_sh),
        .csum   (csum),
        .ch     (ch)
    );

    // SEND lasts exactly one cycle, so the strobe is the state decode itself and the
    // byte is presented live that cycle, then held from the register until tx_done.
    assign tx_flag = (state == ST_SEND);
    assign tx_data = tx_flag ? ch : hold;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            bcd_sh     <= '0;
            fix_sh     <= 1'b0;
            csum       <= '0;
            hold       <= '0;
            tmo        <= '0;
            gap        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            tx_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The cycle carrying the end-of-frame pulse still belongs to the old frame.
                    if (start && !frame_done && !tx_err) begin
                        bcd_sh <= time_bcd;
                        fix_sh <= fix_ok;
                        idx    <= '0;
                        csum   <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    hold  <= ch;
                    tmo   <= TMO_W'(1);
                    if (idx >= CSUM_FIRST && idx <= CSUM_LAST) csum <= csum ^ ch;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            idx   <= idx + 5'd1;
                            gap   <= '0;
                            state <= (IFG_CYCLES > 0) ? ST_GAP : ST_SEND;
                        end
                    end else if (tmo == TMO_W'(TX_TIMEOUT - 1)) begin
                        tx_err <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap == GAP_W'(IFG_CYCLES - 1)) state <= ST_SEND;
                    else gap <= gap + GAP_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnrmc_frame_tx.sv
// Bench for gnrmc_frame_tx: fixed sentence table, randomized frames against a string-level
// model, inter-byte gap, restart suppression, timeout abort and reset mid-frame.
module tb_gnrmc_frame_tx;

    localparam int IFG0 = 0;
    localparam int IFG1 = 3;
    localparam int TMO  = 50;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [1:0]       start_v = '0;
    logic [1:0]       tx_done_v = '0;
    logic [23:0]      time_bcd = '0;
    logic             fix_ok = 1'b0;
    logic [1:0][7:0]  tx_data_v;
    logic [1:0]       tx_flag_v, busy_v, fd_v, err_v;
    int               fd_cnt[2] = '{0, 0};
    int               n_chk = 0;
    int               n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    gnrmc_frame_tx #(.IFG_CYCLES(IFG0), .TX_TIMEOUT(TMO)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]), .time_bcd(time_bcd),
        .fix_ok(fix_ok), .tx_done(tx_done_v[0]), .tx_data(tx_data_v[0]), .tx_flag(tx_flag_v[0]),
        .busy(busy_v[0]), .frame_done(fd_v[0]), .tx_err(err_v[0])
    );

    gnrmc_frame_tx #(.IFG_CYCLES(IFG1), .TX_TIMEOUT(TMO)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]), .time_bcd(time_bcd),
        .fix_ok(fix_ok), .tx_done(tx_done_v[1]), .tx_data(tx_data_v[1]), .tx_flag(tx_flag_v[1]),
        .busy(busy_v[1]), .frame_done(fd_v[1]), .tx_err(err_v[1])
    );

    always @(negedge sys_clk) begin
        if (fd_v[0]) fd_cnt[0]++;
        if (fd_v[1]) fd_cnt[1]++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    // Builds the sentence text directly from the field rules.
    function automatic logic [183:0] model(input logic [23:0] bcd, input logic f);
        byte unsigned b[23];
        string        hdr;
        string        hx;
        logic         bad;
        logic [7:0]   cs;
        logic [3:0]   nib;
        logic [183:0] r;
        hdr = "$GNRMC,";
        hx  = "0123456789ABCDEF";
        bad = 1'b0;
        cs  = 8'h00;
        for (int i = 0; i < 7; i++) b[i] = hdr[i];
        for (int k = 0; k < 6; k++) begin
            nib = bcd[(5-k)*4 +: 4];
            if (nib > 4'd9) bad = 1'b1;
            b[7+k] = (nib > 4'd9) ? 8'h30 : (8'h30 + {4'h0, nib});
        end
        b[13] = "."; b[14] = "0"; b[15] = "0"; b[16] = ",";
        b[17] = (f && !bad) ? "A" : "V";
        for (int i = 1; i <= 17; i++) cs ^= b[i];
        b[18] = "*";
        b[19] = hx[cs[7:4]];
        b[20] = hx[cs[3:0]];
        b[21] = 8'h0D;
        b[22] = 8'h0A;
        for (int i = 0; i < 23; i++) r[(22-i)*8 +: 8] = b[i];
        return r;
    endfunction

    // Drives one frame through DUT d acting as the UART; stop_at < 23 withholds tx_done there.
    task automatic run_frame(input int d, input logic [23:0] bcd, input logic f, input int dly,
                             input logic [183:0] exp, input bit poke, input int stop_at);
        int         ifg, waits, n, fd0;
        logic [7:0] got;
        ifg = (d == 0) ? IFG0 : IFG1;
        fd0 = fd_cnt[d];
        time_bcd = bcd; fix_ok = f; start_v[d] = 1'b1;
        step;
        start_v[d] = 1'b0;
        time_bcd = ~bcd; fix_ok = ~f;
        chk("busy_after_start", busy_v[d], 1);
        for (int i = 0; i < 23; i++) begin
            waits = 0;
            while (!tx_flag_v[d] && waits < 40) begin step; waits++; end
            chk($sformatf("flag_latency[%0d]", i), waits, (i == 0) ? 0 : ifg);
            got = tx_data_v[d];
            chk($sformatf("byte[%0d]", i), got, exp[(22-i)*8 +: 8]);
            if (i == stop_at) begin
                n = 0;
                while (!err_v[d] && n < 100) begin step; n++; end
                chk("timeout_latency", n, TMO);
                chk("timeout_busy", busy_v[d], 0);
                chk("timeout_fd_now", fd_v[d], 0);
                step;
                chk("timeout_err_1cyc", err_v[d], 0);
                chk("timeout_no_fd", fd_cnt[d] - fd0, 0);
                return;
            end
            for (int k = 0; k < dly; k++) begin
                if (poke && i == 8 && k == 0) start_v[d] = 1'b1;
                step;
                start_v[d] = 1'b0;
            end
            chk($sformatf("flag_1cyc[%0d]", i), tx_flag_v[d], 0);
            chk($sformatf("data_hold[%0d]", i), tx_data_v[d], got);
            tx_done_v[d] = 1'b1;
            step;
            tx_done_v[d] = 1'b0;
        end
        chk("frame_done_pulse", fd_v[d], 1);
        chk("busy_at_end", busy_v[d], 0);
        if (poke) start_v[d] = 1'b1;
        step;
        start_v[d] = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (tx_flag_v[d] || busy_v[d]) n++;
            step;
        end
        chk("no_restart", n, 0);
        chk("frame_done_once", fd_cnt[d] - fd0, 1);
        chk("tx_data_idle_hold", tx_data_v[d], 8'h0A);
    endtask

    typedef struct {
        logic [23:0]  bcd;
        logic         fix;
        int           dly;
        logic [183:0] exp;
    } vec_t;

    vec_t        tbl[4];
    logic [23:0] rb;
    logic        rf;

    initial begin
        tbl[0].bcd = 24'h123456; tbl[0].fix = 1'b1; tbl[0].dly = 10; tbl[0].exp = "$GNRMC,123456.00,A*3D\r\n";
        tbl[1].bcd = 24'h123456; tbl[1].fix = 1'b0; tbl[1].dly = 2;  tbl[1].exp = "$GNRMC,123456.00,V*2A\r\n";
        tbl[2].bcd = 24'h000000; tbl[2].fix = 1'b1; tbl[2].dly = 1;  tbl[2].exp = "$GNRMC,000000.00,A*3A\r\n";
        tbl[3].bcd = 24'h1A3456; tbl[3].fix = 1'b1; tbl[3].dly = 3;  tbl[3].exp = "$GNRMC,103456.00,V*28\r\n";

        repeat (3) step;
        for (int d = 0; d < 2; d++) begin
            chk("rst_tx_data", tx_data_v[d], 0);
            chk("rst_flags", {tx_flag_v[d], busy_v[d], fd_v[d], err_v[d]}, 0);
        end
        sys_rst_n = 1'b1;
        step;
        chk("post_rst_idle", {tx_flag_v, busy_v, fd_v, err_v}, 0);

        for (int t = 0; t < 4; t++)
            run_frame(0, tbl[t].bcd, tbl[t].fix, tbl[t].dly, tbl[t].exp, 1'b0, 23);

        for (int r = 0; r < 6; r++) begin
            rb = $urandom;
            if (r % 2 == 0)
                for (int k = 0; k < 6; k++) rb[k*4 +: 4] = 4'($urandom_range(0, 9));
            rf = 1'($urandom);
            run_frame(0, rb, rf, $urandom_range(1, 4), model(rb, rf), 1'b0, 23);
        end

        // Gap of 3 cycles, start pokes mid-frame and in the frame_done cycle.
        run_frame(1, 24'h095959, 1'b1, 2, model(24'h095959, 1'b1), 1'b1, 23);
        rb = 24'h2F1307;
        run_frame(1, rb, 1'b1, 1, model(rb, 1'b1), 1'b1, 23);

        // tx_done withheld at byte 5, then a clean frame.
        run_frame(0, 24'h123456, 1'b1, 2, model(24'h123456, 1'b1), 1'b0, 5);
        run_frame(0, 24'h235959, 1'b0, 3, model(24'h235959, 1'b0), 1'b0, 23);

        // Asynchronous reset in the middle of a frame.
        time_bcd = 24'h111111; fix_ok = 1'b1; start_v[1] = 1'b1;
        step;
        start_v[1] = 1'b0;
        repeat (3) step;
        chk("pre_reset_busy", busy_v[1], 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midrst_tx_data", tx_data_v[1], 0);
        chk("midrst_flags", {tx_flag_v[1], busy_v[1], fd_v[1], err_v[1]}, 0);
        step;
        sys_rst_n = 1'b1;
        step;
        run_frame(1, 24'h000000, 1'b1, 1, model(24'h000000, 1'b1), 1'b0, 23);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
